// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/halt/step sequencer producing the core advance enable
// Boot delay, one PC breakpoint and a retired-instruction counter for a single-cycle core.
module cpu_run_controller #(
  parameter int BOOT_CYCLES = 4,
  parameter bit AUTO_RUN    = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             Clk_i,
  input  logic             Rst_n_i,
  input  logic             Run_Req_i,
  input  logic             Halt_Req_i,
  input  logic             Step_Req_i,
  input  logic             Bp_Enable_i,
  input  logic [31:0]      Bp_Addr_i,
  input  logic [31:0]      PC_Current_i,
  input  logic             Clr_Count_i,
  output logic             cpu_enable_o,
  output logic [1:0]       State_o,
  output logic             Halted_o,
  output logic             Bp_Hit_o,
  output logic             Step_Done_o,
  output logic [CNT_W-1:0] Instr_Count_o
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    HALTED  = 2'd1,
    RUNNING = 2'd2,
    STEP    = 2'd3
  } state_t;

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [BW-1:0]     boot_cnt_q, boot_cnt_d;
  logic              bp_skip_q, bp_skip_d;
  logic              bp_hit_q, bp_hit_d;
  logic              halted_q;
  logic              step_done_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bp_match;
  logic              cpu_enable;

  // bp_skip lets a resume execute the instruction that triggered the halt
  assign bp_match = Bp_Enable_i & (PC_Current_i == Bp_Addr_i) & ~bp_skip_q;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    bp_skip_d  = bp_skip_q;
    bp_hit_d   = bp_hit_q;
    cpu_enable = 1'b0;
    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = AUTO_RUN ? RUNNING : HALTED;
        end
      end
      HALTED: begin
        if (Halt_Req_i) begin
          state_d = HALTED;
        end else if (Step_Req_i) begin
          state_d   = STEP;
          bp_skip_d = 1'b1;
          bp_hit_d  = 1'b0;
        end else if (Run_Req_i) begin
          state_d   = RUNNING;
          bp_skip_d = 1'b1;
          bp_hit_d  = 1'b0;
        end
      end
      RUNNING: begin
        cpu_enable = ~bp_match;
        if (bp_match) begin
          state_d  = HALTED;
          bp_hit_d = 1'b1;
        end else begin
          bp_skip_d = 1'b0;
          if (Halt_Req_i) begin
            state_d = HALTED;
          end
        end
      end
      STEP: begin
        cpu_enable = 1'b1;
        bp_skip_d  = 1'b0;
        state_d    = HALTED;
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Clr_Count_i) begin
      cnt_d = '0;
    end else if (cpu_enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q     <= BOOT;
      boot_cnt_q  <= '0;
      bp_skip_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
      halted_q    <= 1'b0;
      step_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      bp_skip_q   <= bp_skip_d;
      bp_hit_q    <= bp_hit_d;
      halted_q    <= (state_d == HALTED);
      step_done_q <= (state_q == STEP);
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_enable_o  = cpu_enable;
  assign State_o       = state_q;
  assign Halted_o      = halted_q;
  assign Bp_Hit_o      = bp_hit_q;
  assign Step_Done_o   = step_done_q;
  assign Instr_Count_o = cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed scoreboard bench for cpu_run_controller
// The bench plays the core: its PC advances by 4 on every enabled cycle.
module tb_cpu_run_controller;

  localparam int CNT_W = 4;

  localparam int K_EN = 0, K_ST = 1, K_CNT = 2, K_HIT = 3, K_SD = 4, K_HLT = 5, K_PC = 6;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             run_req, halt_req, step_req, bp_en, clr;
  logic [31:0]      bp_addr, pc;
  logic             cpu_en;
  logic [1:0]       state;
  logic             halted, bp_hit, step_done;
  logic [CNT_W-1:0] count;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  cpu_run_controller #(.BOOT_CYCLES(4), .AUTO_RUN(1'b1), .CNT_W(CNT_W)) dut (
    .Clk_i        (clk),
    .Rst_n_i      (rst_n),
    .Run_Req_i    (run_req),
    .Halt_Req_i   (halt_req),
    .Step_Req_i   (step_req),
    .Bp_Enable_i  (bp_en),
    .Bp_Addr_i    (bp_addr),
    .PC_Current_i (pc),
    .Clr_Count_i  (clr),
    .cpu_enable_o (cpu_en),
    .State_o      (state),
    .Halted_o     (halted),
    .Bp_Hit_o     (bp_hit),
    .Step_Done_o  (step_done),
    .Instr_Count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_EN:    return {31'd0, cpu_en};
      K_ST:    return {30'd0, state};
      K_CNT:   return {{(32-CNT_W){1'b0}}, count};
      K_HIT:   return {31'd0, bp_hit};
      K_SD:    return {31'd0, step_done};
      K_HLT:   return {31'd0, halted};
      default: return pc;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance one clock; the modelled PC moves if the enable was high before the edge.
  task automatic tick();
    logic en_s;
    en_s = cpu_en;
    @(posedge clk);
    #1;
    if (en_s === 1'b1) pc = pc + 32'd4;
  endtask

  initial begin
    rst_n = 1'b0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst_state", K_ST, 0);
    expect_out("rst_en", K_EN, 0);
    expect_out("rst_count", K_CNT, 0);
    expect_out("rst_bphit", K_HIT, 0);
    expect_out("rst_stepdone", K_SD, 0);
    expect_out("rst_halted", K_HLT, 0);
    check_all();
    rst_n = 1'b1;

    // boot: four disabled cycles, requests ignored
    run_req = 1'b1; step_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("boot_en_%0d", i), K_EN, 0);
      expect_out($sformatf("boot_state_%0d", i), K_ST, 0);
      check_all();
      tick();
    end
    run_req = 1'b0; step_req = 1'b0;
    expect_out("run_state", K_ST, 2);
    expect_out("run_en", K_EN, 1);
    check_all();
    repeat (3) tick();
    expect_out("count_after3", K_CNT, 3);
    check_all();

    // breakpoint at 0x10
    tick();
    expect_out("bp_pc", K_PC, 32'h10);
    expect_out("bp_en_low", K_EN, 0);
    check_all();
    tick();
    expect_out("bp_state", K_ST, 1);
    expect_out("bp_hit", K_HIT, 1);
    expect_out("bp_halted", K_HLT, 1);
    expect_out("bp_count", K_CNT, 4);
    expect_out("bp_pc_hold", K_PC, 32'h10);
    check_all();

    // resume executes the breakpointed instruction
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    expect_out("resume_state", K_ST, 2);
    expect_out("resume_bphit", K_HIT, 0);
    expect_out("resume_en", K_EN, 1);
    check_all();
    tick();
    expect_out("resume_pc", K_PC, 32'h14);
    expect_out("resume_count", K_CNT, 5);
    check_all();

    // one-cycle halt still retires that cycle
    halt_req = 1'b1;
    expect_out("halt_same_en", K_EN, 1);
    check_all();
    tick();
    halt_req = 1'b0;
    expect_out("halt_state", K_ST, 1);
    expect_out("halt_count", K_CNT, 6);
    expect_out("halt_en", K_EN, 0);
    check_all();

    // three steps; a step request during STEP is ignored
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      tick();
      expect_out($sformatf("step_state_%0d", i), K_ST, 3);
      expect_out($sformatf("step_en_%0d", i), K_EN, 1);
      check_all();
      tick();
      step_req = 1'b0;
      expect_out($sformatf("step_done_%0d", i), K_SD, 1);
      expect_out($sformatf("step_back_%0d", i), K_ST, 1);
      expect_out($sformatf("step_cnt_%0d", i), K_CNT, 7 + i);
      check_all();
      tick();
      expect_out($sformatf("step_gap_en_%0d", i), K_EN, 0);
      expect_out($sformatf("step_gap_sd_%0d", i), K_SD, 0);
      check_all();
    end

    // a breakpoint on the current PC does not block a step
    bp_addr = pc;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    expect_out("bpstep_en", K_EN, 1);
    check_all();
    tick();
    expect_out("bpstep_count", K_CNT, 10);
    check_all();

    // halt wins over run in HALTED
    halt_req = 1'b1; run_req = 1'b1;
    tick();
    halt_req = 1'b0; run_req = 1'b0;
    expect_out("haltrun_state", K_ST, 1);
    expect_out("haltrun_en", K_EN, 0);
    check_all();

    // counter wrap and clear priority
    bp_en = 1'b0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (5) tick();
    expect_out("cnt_15", K_CNT, 15);
    check_all();
    tick();
    expect_out("cnt_wrap", K_CNT, 0);
    check_all();
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    expect_out("cnt_clr", K_CNT, 0);
    check_all();

    // breakpoint programmed while running acts in the same cycle
    bp_addr = pc; bp_en = 1'b1;
    expect_out("bp_live_en", K_EN, 0);
    check_all();
    bp_en = 1'b0;
    expect_out("bp_live_off", K_EN, 1);
    check_all();

    // reset during STEP aborts at once
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    expect_out("prerst_state", K_ST, 3);
    check_all();
    rst_n = 1'b0;
    expect_out("midstep_rst_en", K_EN, 0);
    expect_out("midstep_rst_state", K_ST, 0);
    expect_out("midstep_rst_cnt", K_CNT, 0);
    check_all();
    rst_n = 1'b1;
    repeat (4) tick();
    expect_out("reboot_state", K_ST, 2);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
